scmp_useq: RTL
==============

Name: scmp_useq

Overview:
- Microcode sequencer for the SC/MP core. Owns the microprogram counter (uPC) and steps it through the microcode ROM.
- Stalls the uPC on external bus cycles. Dispatches to the opcode entry point supplied by the opcode decoder (op_pc/op_dly).
- Implements the HALT/CONT wait and the DLY instruction's long microcycle countdown.
- Sits between the decoder, the microcode ROM and the bus interface.

Parameters:
UPC_W, 8, width of the microprogram counter and all microcode addresses
FETCH_ADDR, 8'h00, microcode address of the FETCH label; reset and post-HALT target
HALT_ADDR, 8'h01, microcode address of the HALT label; a dispatch to it enters the HALT state
DLY_W, 18, width of the delay counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
op_pc  in  UPC_W  entry point from the opcode decoder for the current IR
op_dly  in  1  decoder flag: current opcode is DLY
mc_nxt  in  2  next-address mode of the current microinstruction: 00 seq, 01 jump, 10 dispatch, 11 cond jump
mc_tgt  in  UPC_W  jump target field of the current microinstruction
mc_bus  in  1  current microinstruction performs a bus cycle
bus_ack  in  1  bus interface completes the requested cycle
cond  in  1  datapath condition for mc_nxt=11
acc  in  8  accumulator value, used for the DLY count
disp  in  8  displacement byte, used for the DLY count
cont  in  1  external CONT input, level-sensitive
upc  out  UPC_W  current microcode address to the ROM
upc_en  out  1  current microinstruction retires this cycle; enables datapath writes
bus_req  out  1  bus cycle requested
halted  out  1  core is in HALT
dly_busy  out  1  DLY countdown in progress

Behaviour:
- States: RUN, DLY, HALT.
- Reset (async): state=RUN, upc=FETCH_ADDR, dly_cnt=0.
- While rst_n=0, all outputs are forced as follows: upc_en=0, bus_req=0, halted=0, dly_busy=0.
- A reset asserted mid-DLY or mid-HALT aborts that state immediately.

RUN state:
- bus_req = mc_bus.
- retire = !mc_bus | bus_ack; upc_en = retire.
- If mc_bus=1 and bus_ack=0: upc holds and no datapath enable is given. There is no limit on stall length.
- Next upc on retire:
  - 00: upc+1, modulo 2^UPC_W, so 0xFF wraps to 0x00.
  - 01: mc_tgt.
  - 11: cond ? mc_tgt : upc+1.
  - 10 (dispatch), op_pc==HALT_ADDR: upc=HALT_ADDR, state goes to HALT.
  - 10, op_dly=1: upc=op_pc; dly_cnt = 13 + 2*acc + 514*disp, zero-extended to DLY_W (max 131593); state goes to DLY.
  - 10, otherwise: upc=op_pc.

DLY state:
- upc holds, upc_en=0, bus_req=0, dly_busy=1.
- dly_cnt decrements every cycle. When dly_cnt==1, next state is RUN.
- DLY therefore occupies exactly N cycles, where N is the loaded count. The DLY microroutine at op_pc then executes normally.
- Inputs mc_* are ignored in this state.

HALT state:
- upc=HALT_ADDR, upc_en=0, bus_req=0, halted=1.
- In any HALT cycle with cont=1: next state is RUN with upc=FETCH_ADDR.
- The minimum HALT duration is 1 cycle, even if cont is already high on entry.
- cont is ignored in RUN and DLY.

Timing and priority:
- All state/upc updates are registered on the rising edge of clk.
- upc_en and bus_req are combinational from state and inputs.
- The next-address mux is fully registered: zero added latency beyond one cycle per retired microinstruction.
- Dispatch priority: HALT_ADDR check first, then op_dly, then plain dispatch.

Test Plan:
- Reset release with mc_nxt=00, mc_bus=0 for 3 cycles -> upc 0x00,0x01,0x02,0x03; upc_en=1 each cycle.
- mc_bus=1, bus_ack low for 4 cycles then high -> bus_req=1 for 5 cycles; upc_en=1 only on the 5th; upc advances once.
- upc=0xFF with mc_nxt=00 -> upc=0x00. mc_nxt=11, mc_tgt=0x40, cond=0/1 -> 0x00+1 / 0x40.
- Dispatch with op_dly=1, acc=0x02, disp=0x01 -> dly_busy=1 for exactly 531 cycles, then RUN with upc=op_pc; the same test repeated with acc=0, disp=0 -> 13 cycles.
- Dispatch with op_pc=HALT_ADDR, cont=0 for 10 cycles then 1 -> halted=1 for 11 cycles; next upc=FETCH_ADDR; upc_en=0 throughout HALT.
- Assert rst_n=0 at cycle 100 of a 131593-cycle DLY (acc=0xFF, disp=0xFF) -> dly_busy=0 and upc=FETCH_ADDR immediately; normal sequencing resumes after release.

Source files
------------

// File: rtl/scmp_useq_if.sv
// Signal bundle between the SC/MP microcode sequencer and its neighbours
// (opcode decoder, microcode ROM, bus interface, datapath, CONT pin).
// The sequencer side uses the master modport because it issues bus requests;
// everything that feeds or consumes the sequencer uses the slave modport.
interface scmp_useq_if #(
    parameter int UPC_W = 8
);
    logic [UPC_W-1:0] op_pc;
    logic             op_dly;
    logic [1:0]       mc_nxt;
    logic [UPC_W-1:0] mc_tgt;
    logic             mc_bus;
    logic             bus_ack;
    logic             cond;
    logic [7:0]       acc;
    logic [7:0]       disp;
    logic             cont;
    logic [UPC_W-1:0] upc;
    logic             upc_en;
    logic             bus_req;
    logic             halted;
    logic             dly_busy;

    modport master (
        input  op_pc, op_dly, mc_nxt, mc_tgt, mc_bus, bus_ack, cond, acc, disp, cont,
        output upc, upc_en, bus_req, halted, dly_busy
    );

    modport slave (
        output op_pc, op_dly, mc_nxt, mc_tgt, mc_bus, bus_ack, cond, acc, disp, cont,
        input  upc, upc_en, bus_req, halted, dly_busy
    );
endinterface

// File: rtl/scmp_useq.sv
// SC/MP microcode sequencer: owns the microprogram counter, stalls it on
// unacknowledged bus cycles, dispatches to decoder entry points and runs the
// HALT/CONT wait and the DLY instruction countdown.
module scmp_useq #(
    parameter int               UPC_W      = 8,
    parameter logic [UPC_W-1:0] FETCH_ADDR = 8'h00,
    parameter logic [UPC_W-1:0] HALT_ADDR  = 8'h01,
    parameter int               DLY_W      = 18
) (
    input  logic           clk,
    input  logic           rst_n,
    scmp_useq_if.master    sif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DLY  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [UPC_W-1:0] upc_q, upc_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic             retire;
    logic [DLY_W-1:0] acc_ext, disp_ext, dly_load;

    // A microinstruction retires unless it is waiting on its bus cycle
    assign retire   = !sif.mc_bus || sif.bus_ack;

    // DLY length: 13 + 2*acc + 514*disp, always fits in the counter
    assign acc_ext  = DLY_W'(sif.acc);
    assign disp_ext = DLY_W'(sif.disp);
    assign dly_load = DLY_W'(13) + (acc_ext << 1) + (disp_ext * DLY_W'(514));

    // State, microprogram counter and delay counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            upc_q     <= FETCH_ADDR;
            dly_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            dly_cnt_q <= dly_cnt_d;
        end
    end

    // Next-state and next-address selection
    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        dly_cnt_d = dly_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (retire) begin
                    case (sif.mc_nxt)
                        2'b00: upc_d = upc_q + UPC_W'(1);
                        2'b01: upc_d = sif.mc_tgt;
                        2'b11: upc_d = sif.cond ? sif.mc_tgt : upc_q + UPC_W'(1);
                        default: begin
                            if (sif.op_pc == HALT_ADDR) begin
                                upc_d   = HALT_ADDR;
                                state_d = ST_HALT;
                            end else if (sif.op_dly) begin
                                upc_d     = sif.op_pc;
                                dly_cnt_d = dly_load;
                                state_d   = ST_DLY;
                            end else begin
                                upc_d = sif.op_pc;
                            end
                        end
                    endcase
                end
            end
            ST_DLY: begin
                dly_cnt_d = dly_cnt_q - DLY_W'(1);
                if (dly_cnt_q == DLY_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                upc_d = HALT_ADDR;
                if (sif.cont) begin
                    state_d = ST_RUN;
                    upc_d   = FETCH_ADDR;
                end
            end
            default: begin
                state_d = ST_RUN;
                upc_d   = FETCH_ADDR;
            end
        endcase
    end

    // Outputs are combinational and held inactive while reset is asserted
    always_comb begin
        sif.upc      = upc_q;
        sif.upc_en   = rst_n && (state_q == ST_RUN) && retire;
        sif.bus_req  = rst_n && (state_q == ST_RUN) && sif.mc_bus;
        sif.halted   = rst_n && (state_q == ST_HALT);
        sif.dly_busy = rst_n && (state_q == ST_DLY);
    end

endmodule
